// File: rtl/life_pkg.sv
// Shared constants and helpers for the life grid display.
// Build option: LIFE_GRID_LINES_EN (grid-line overlay, see life_grid_display).
package life_pkg;

   localparam int RGB_W   = 12;
   localparam int COORD_W = 11;

   localparam logic [RGB_W-1:0] DEAD_RGB_DEF  = 12'h000;
   localparam logic [RGB_W-1:0] ALIVE_RGB_DEF = 12'hFFF;
   localparam logic [RGB_W-1:0] GRID_RGB      = 12'h444;

   // Flat bit index of a cell: row*grid_w + col. Wide enough for a 64x64 grid.
   function automatic logic [12:0] cell_index(input logic [COORD_W-1:0] row,
                                              input logic [COORD_W-1:0] col,
                                              input int unsigned        grid_w);
      logic [12:0] r;
      logic [12:0] c;
      logic [12:0] w;
      r = 13'(row);
      c = 13'(col);
      w = 13'(grid_w);
      return (r * w) + c;
   endfunction

endpackage

// File: rtl/life_gen_buffer.sv
// Pending/display double buffer for life generations.
// A new generation is parked in the pending buffer and only moves to the
// display buffer on frame_start, so a frame never shows two generations.
module life_gen_buffer #(
   parameter int CELLS = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CELLS-1:0] alive_i,
   input  logic             alive_valid_i,
   input  logic             frame_start_i,
   output logic             alive_ready_o,
   output logic [CELLS-1:0] disp_o
);

   logic [CELLS-1:0] pend_q, pend_d;
   logic [CELLS-1:0] disp_q, disp_d;
   logic             full_q, full_d;
   logic             accept;
   logic             commit;

   // Handshake and commit decisions; accept and commit cannot coincide
   // because accept requires an empty pending buffer.
   always_comb begin
      accept = alive_valid_i && !full_q;
      commit = frame_start_i && full_q;
      pend_d = accept ? alive_i : pend_q;
      disp_d = commit ? pend_q : disp_q;
      full_d = full_q;
      if (accept) begin
         full_d = 1'b1;
      end else if (commit) begin
         full_d = 1'b0;
      end
   end

   // Buffer state; reset drops any parked generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         disp_q <= '0;
         full_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         disp_q <= disp_d;
         full_q <= full_d;
      end
   end

   assign alive_ready_o = !full_q;
   assign disp_o        = disp_q;

endmodule

// File: rtl/life_grid_display.sv
// Life grid renderer: double-buffered generation store plus a two-stage
// pixel pipeline (cell lookup, then colour).
// Build option: LIFE_GRID_LINES_EN draws GRID_RGB on the first pixel row and
// column of every in-grid cell.
module life_grid_display
   import life_pkg::*;
#(
   parameter int               GRID_W     = 16,
   parameter int               GRID_H     = 16,
   parameter int               CELL_SHIFT = 2,
   parameter logic [RGB_W-1:0] ALIVE_RGB  = ALIVE_RGB_DEF,
   parameter logic [RGB_W-1:0] DEAD_RGB   = DEAD_RGB_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [COORD_W-1:0]       x,
   input  logic [COORD_W-1:0]       y,
   input  logic                     pix_en,
   input  logic                     frame_start,
   input  logic [GRID_W*GRID_H-1:0] alive,
   input  logic                     alive_valid,
   output logic                     alive_ready,
   output logic [RGB_W-1:0]         rgb,
   output logic                     rgb_valid
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   logic [CELLS-1:0] disp;

   life_gen_buffer #(
      .CELLS (CELLS)
   ) u_gen_buffer (
      .clk           (clk),
      .rst_n         (rst_n),
      .alive_i       (alive),
      .alive_valid_i (alive_valid),
      .frame_start_i (frame_start),
      .alive_ready_o (alive_ready),
      .disp_o        (disp)
   );

   logic [COORD_W-1:0] cx_q, cx_d;
   logic [COORD_W-1:0] cy_q, cy_d;
   logic               in_grid_q, in_grid_d;
   logic               pen_q, pen_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;
   logic               rgb_valid_q, rgb_valid_d;
   logic [IDX_W-1:0]   idx;
   logic               cell_on;

`ifdef LIFE_GRID_LINES_EN
   localparam logic [COORD_W-1:0] OFF_MASK = COORD_W'((1 << CELL_SHIFT) - 1);
   logic edge_q, edge_d;
`endif

   // Stage 1: pixel -> cell coordinates and grid membership.
   always_comb begin
      cx_d      = x >> CELL_SHIFT;
      cy_d      = y >> CELL_SHIFT;
      in_grid_d = (cx_d < COORD_W'(GRID_W)) && (cy_d < COORD_W'(GRID_H));
      pen_d     = pix_en;
`ifdef LIFE_GRID_LINES_EN
      edge_d    = ((x & OFF_MASK) == '0) || ((y & OFF_MASK) == '0);
`endif
   end

   // Stage 2: cell lookup and colour. The index is forced to zero off-grid so
   // a far coordinate can never address beyond the display buffer.
   always_comb begin
      idx         = in_grid_q ? IDX_W'(cell_index(cy_q, cx_q, GRID_W)) : '0;
      cell_on     = in_grid_q && disp[idx];
      rgb_valid_d = pen_q;
      rgb_d       = '0;
      if (pen_q) begin
`ifdef LIFE_GRID_LINES_EN
         if (in_grid_q && edge_q) begin
            rgb_d = GRID_RGB;
         end else begin
            rgb_d = cell_on ? ALIVE_RGB : DEAD_RGB;
         end
`else
         rgb_d = cell_on ? ALIVE_RGB : DEAD_RGB;
`endif
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx_q        <= '0;
         cy_q        <= '0;
         in_grid_q   <= 1'b0;
         pen_q       <= 1'b0;
         rgb_q       <= '0;
         rgb_valid_q <= 1'b0;
`ifdef LIFE_GRID_LINES_EN
         edge_q      <= 1'b0;
`endif
      end else begin
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         in_grid_q   <= in_grid_d;
         pen_q       <= pen_d;
         rgb_q       <= rgb_d;
         rgb_valid_q <= rgb_valid_d;
`ifdef LIFE_GRID_LINES_EN
         edge_q      <= edge_d;
`endif
      end
   end

   assign rgb       = rgb_q;
   assign rgb_valid = rgb_valid_q;

endmodule
